// File: rtl/reg_file_rename.sv
// Purpose : architectural register file with per-register rename (ROB tag) state.
// Latency : reads are combinational (0 cycles); commit/rename/roll take effect next cycle.
// Backpr. : none; rdy low freezes all state, and reads keep reflecting stored state.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rdy                            global ready; low = hold state, ignore inputs
//   Dis_rs1/2 -> Dis_busy/tag/val  dispatch source-operand lookup (x0 reads as 0)
//   Dis_rename_flag/rd/ROB_idx     dispatch renames rd to an allocated ROB entry
//   ROB_write_flag/rd/idx/val      ROB commit port; a matching tag clears busy
//   ROB_roll                       flush: clear every busy bit, drop the rename
//
// Build option: define RF_BYPASS_EN to forward a same-cycle commit straight to
// the dispatch read ports. Without it, dispatch sees the register still busy
// with the committing tag and resolves the value through the ROB.
module reg_file_rename #(
    parameter int ROB_IDX_W = 4,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [4:0]           Dis_rs1,
    input  logic [4:0]           Dis_rs2,
    output logic                 Dis_busy1,
    output logic [ROB_IDX_W-1:0] Dis_tag1,
    output logic [31:0]          Dis_val1,
    output logic                 Dis_busy2,
    output logic [ROB_IDX_W-1:0] Dis_tag2,
    output logic [31:0]          Dis_val2,
    input  logic                 Dis_rename_flag,
    input  logic [4:0]           Dis_rd,
    input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
    input  logic                 ROB_write_flag,
    input  logic [4:0]           ROB_rd,
    input  logic [ROB_IDX_W-1:0] ROB_idx,
    input  logic [31:0]          ROB_val,
    input  logic                 ROB_roll
);

    logic [31:0]          val_q [REG_NUM];
    logic [31:0]          val_d [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_q [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_d [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;

    logic commit_en;
    logic commit_clears;
    logic rename_en;

    // x0 is hard-wired: neither port may ever touch entry 0.
    assign commit_en     = rdy && ROB_write_flag && (ROB_rd != 5'd0);
    // Only the commit of the newest writer frees the register; an older
    // commit still lands its value but a younger rename keeps ownership.
    assign commit_clears = commit_en && busy_q[ROB_rd] && (tag_q[ROB_rd] == ROB_idx);
    assign rename_en     = rdy && Dis_rename_flag && (Dis_rd != 5'd0) && !ROB_roll;

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;

        if (commit_en) begin
            val_d[ROB_rd] = ROB_val;
        end
        if (commit_clears) begin
            busy_d[ROB_rd] = 1'b0;
        end

        // A jump commit raises write and roll together, so the value write
        // above still stands; only rename state is discarded. Tags are left
        // stale because busy alone gates their meaning.
        if (rdy && ROB_roll) begin
            busy_d = '0;
        end else if (rename_en) begin
            // Applied after the commit so rename wins a same-register race.
            busy_d[Dis_rd] = 1'b1;
            tag_d[Dis_rd]  = Dis_ROB_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

`ifdef RF_BYPASS_EN
    logic fwd_hit1;
    logic fwd_hit2;
    // commit_clears already implies rd != 0, rdy, and a busy entry whose tag
    // matches the committing ROB index.
    assign fwd_hit1 = commit_clears && (Dis_rs1 == ROB_rd);
    assign fwd_hit2 = commit_clears && (Dis_rs2 == ROB_rd);
`endif

    always_comb begin
        Dis_busy1 = 1'b0;
        Dis_tag1  = '0;
        Dis_val1  = '0;
        if (Dis_rs1 != 5'd0) begin
            Dis_busy1 = busy_q[Dis_rs1];
            Dis_tag1  = tag_q[Dis_rs1];
            Dis_val1  = val_q[Dis_rs1];
`ifdef RF_BYPASS_EN
            if (fwd_hit1) begin
                Dis_busy1 = 1'b0;
                Dis_val1  = ROB_val;
            end
`endif
        end
    end

    always_comb begin
        Dis_busy2 = 1'b0;
        Dis_tag2  = '0;
        Dis_val2  = '0;
        if (Dis_rs2 != 5'd0) begin
            Dis_busy2 = busy_q[Dis_rs2];
            Dis_tag2  = tag_q[Dis_rs2];
            Dis_val2  = val_q[Dis_rs2];
`ifdef RF_BYPASS_EN
            if (fwd_hit2) begin
                Dis_busy2 = 1'b0;
                Dis_val2  = ROB_val;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic [4:0]   Dis_rs1, Dis_rs2;
    logic         Dis_busy1, Dis_busy2;
    logic [W-1:0] Dis_tag1, Dis_tag2;
    logic [31:0]  Dis_val1, Dis_val2;
    logic         Dis_rename_flag;
    logic [4:0]   Dis_rd;
    logic [W-1:0] Dis_ROB_idx;
    logic         ROB_write_flag;
    logic [4:0]   ROB_rd;
    logic [W-1:0] ROB_idx;
    logic [31:0]  ROB_val;
    logic         ROB_roll;

    always #5 clk = ~clk;

    reg_file_rename #(.ROB_IDX_W(W), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .Dis_rs1(Dis_rs1), .Dis_rs2(Dis_rs2),
        .Dis_busy1(Dis_busy1), .Dis_tag1(Dis_tag1), .Dis_val1(Dis_val1),
        .Dis_busy2(Dis_busy2), .Dis_tag2(Dis_tag2), .Dis_val2(Dis_val2),
        .Dis_rename_flag(Dis_rename_flag), .Dis_rd(Dis_rd), .Dis_ROB_idx(Dis_ROB_idx),
        .ROB_write_flag(ROB_write_flag), .ROB_rd(ROB_rd), .ROB_idx(ROB_idx),
        .ROB_val(ROB_val), .ROB_roll(ROB_roll)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what each architectural register holds, whether it
    // waits on a producer, and which ROB entry that producer is.
    int unsigned m_val  [32];
    bit          m_busy [32];
    int unsigned m_tag  [32];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
    endtask

    // One clock of architectural behaviour: commit lands first, then either
    // the flush or the rename decides the rename state.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (ROB_write_flag && ROB_rd != 0) begin
                m_val[ROB_rd] = ROB_val;
                if (m_busy[ROB_rd] && m_tag[ROB_rd] == ROB_idx) m_busy[ROB_rd] = 0;
            end
            if (ROB_roll) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (Dis_rename_flag && Dis_rd != 0) begin
                m_busy[Dis_rd] = 1;
                m_tag[Dis_rd]  = Dis_ROB_idx;
            end
        end
    endtask

    task automatic exp_read(input logic [4:0] rs, output logic b, output logic [W-1:0] t,
                            output logic [31:0] v);
        b = 0; t = 0; v = 0;
        if (rs != 0) begin
            b = m_busy[rs]; t = W'(m_tag[rs]); v = m_val[rs];
`ifdef RF_BYPASS_EN
            if (rdy && ROB_write_flag && ROB_rd == rs && m_busy[rs] && m_tag[rs] == ROB_idx) begin
                b = 0; v = ROB_val;
            end
`endif
        end
    endtask

    // Tag is only meaningful while busy, so it is compared only then.
    task automatic check_reads();
        logic b; logic [W-1:0] t; logic [31:0] v;
        exp_read(Dis_rs1, b, t, v);
        check("m_busy1", Dis_busy1, b);
        if (b) check("m_tag1", Dis_tag1, t);
        check("m_val1", Dis_val1, v);
        exp_read(Dis_rs2, b, t, v);
        check("m_busy2", Dis_busy2, b);
        if (b) check("m_tag2", Dis_tag2, t);
        check("m_val2", Dis_val2, v);
    endtask

    task automatic set_idle();
        rst = 0; rdy = 1;
        Dis_rs1 = 0; Dis_rs2 = 0;
        Dis_rename_flag = 0; Dis_rd = 0; Dis_ROB_idx = 0;
        ROB_write_flag = 0; ROB_rd = 0; ROB_idx = 0; ROB_val = 0; ROB_roll = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        set_idle();
    endtask

    task automatic cyc();
        #1;
        check_reads();
        tick();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        set_idle();
        @(negedge clk);
        do_reset();

        // Reset state
        Dis_rs1 = 5; Dis_rs2 = 0; #1;
        check("rst_busy1", Dis_busy1, 0); check("rst_val1", Dis_val1, 0);
        check("rst_busy2", Dis_busy2, 0); check("rst_val2", Dis_val2, 0);
        tick();

        // Rename then matching commit
        Dis_rename_flag = 1; Dis_rd = 5; Dis_ROB_idx = 3; cyc();
        Dis_rs1 = 5; #1;
        check("ren_busy1", Dis_busy1, 1); check("ren_tag1", Dis_tag1, 3);
        ROB_write_flag = 1; ROB_rd = 5; ROB_idx = 3; ROB_val = 32'h12345678;
        cyc();
        Dis_rs1 = 5; #1;
        check("cmt_busy1", Dis_busy1, 0); check("cmt_val1", Dis_val1, 32'h12345678);
        tick();

        // Older commit must not free a younger rename
        Dis_rename_flag = 1; Dis_rd = 7; Dis_ROB_idx = 2; cyc();
        Dis_rename_flag = 1; Dis_rd = 7; Dis_ROB_idx = 6; cyc();
        ROB_write_flag = 1; ROB_rd = 7; ROB_idx = 2; ROB_val = 32'hAA; cyc();
        Dis_rs1 = 7; #1;
        check("old_val", Dis_val1, 32'hAA); check("old_busy", Dis_busy1, 1);
        check("old_tag", Dis_tag1, 6);
        ROB_write_flag = 1; ROB_rd = 7; ROB_idx = 6; ROB_val = 32'hBB; tick();
        Dis_rs1 = 7; #1;
        check("young_busy", Dis_busy1, 0); check("young_val", Dis_val1, 32'hBB);
        tick();

        // Same-cycle commit and rename to one register: rename wins busy/tag
        Dis_rename_flag = 1; Dis_rd = 9; Dis_ROB_idx = 1; cyc();
        ROB_write_flag = 1; ROB_rd = 9; ROB_idx = 1; ROB_val = 32'h55;
        Dis_rename_flag = 1; Dis_rd = 9; Dis_ROB_idx = 4; cyc();
        Dis_rs2 = 9; #1;
        check("race_val", Dis_val2, 32'h55); check("race_busy", Dis_busy2, 1);
        check("race_tag", Dis_tag2, 4);
        tick();

        // Roll with a commit and a rename in the same cycle
        Dis_rename_flag = 1; Dis_rd = 3; Dis_ROB_idx = 5; cyc();
        Dis_rename_flag = 1; Dis_rd = 4; Dis_ROB_idx = 6; cyc();
        ROB_roll = 1; ROB_write_flag = 1; ROB_rd = 1; ROB_idx = 0; ROB_val = 32'h100;
        Dis_rename_flag = 1; Dis_rd = 8; Dis_ROB_idx = 7; cyc();
        Dis_rs1 = 3; Dis_rs2 = 4; #1;
        check("roll_busy3", Dis_busy1, 0); check("roll_busy4", Dis_busy2, 0);
        tick();
        Dis_rs1 = 1; Dis_rs2 = 8; #1;
        check("roll_val1", Dis_val1, 32'h100); check("roll_busy8", Dis_busy2, 0);
        tick();

        // x0 is immutable
        Dis_rename_flag = 1; Dis_rd = 0; Dis_ROB_idx = 5;
        ROB_write_flag = 1; ROB_rd = 0; ROB_idx = 5; ROB_val = 32'hFFFF; cyc();
        Dis_rs1 = 0; #1;
        check("x0_busy", Dis_busy1, 0); check("x0_val", Dis_val1, 0);
        tick();

        // Same-cycle commit seen by dispatch
        Dis_rename_flag = 1; Dis_rd = 5; Dis_ROB_idx = 3; cyc();
        ROB_write_flag = 1; ROB_rd = 5; ROB_idx = 3; ROB_val = 32'h77; Dis_rs1 = 5; #1;
`ifdef RF_BYPASS_EN
        check("byp_busy", Dis_busy1, 0); check("byp_val", Dis_val1, 32'h77);
`else
        check("nobyp_busy", Dis_busy1, 1); check("nobyp_tag", Dis_tag1, 3);
`endif
        tick();

        // rdy low freezes everything
        Dis_rename_flag = 1; Dis_rd = 6; Dis_ROB_idx = 2; cyc();
        rdy = 0; ROB_write_flag = 1; ROB_rd = 6; ROB_idx = 2; ROB_val = 32'h99;
        Dis_rename_flag = 1; Dis_rd = 10; Dis_ROB_idx = 9; ROB_roll = 1; cyc();
        Dis_rs1 = 6; Dis_rs2 = 10; #1;
        check("frz_busy6", Dis_busy1, 1); check("frz_tag6", Dis_tag1, 2);
        check("frz_val6", Dis_val1, 0); check("frz_busy10", Dis_busy2, 0);
        tick();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            rdy             = ($urandom_range(0, 7) != 0);
            Dis_rs1         = 5'($urandom_range(0, 7));
            Dis_rs2         = 5'($urandom_range(0, 7));
            Dis_rename_flag = $urandom_range(0, 1) == 1;
            Dis_rd          = 5'($urandom_range(0, 7));
            Dis_ROB_idx     = W'($urandom);
            ROB_write_flag  = $urandom_range(0, 1) == 1;
            ROB_rd          = 5'($urandom_range(0, 7));
            ROB_idx         = ($urandom_range(0, 1) == 1) ? W'(m_tag[ROB_rd]) : W'($urandom);
            ROB_val         = $urandom;
            ROB_roll        = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
